// File: rtl/lsu_mem_access_if.sv
// Data-memory request/acknowledge bus between the load/store unit and data memory.
// Single outstanding request: req is held with we/addr/be/wdata stable until ack.
interface lsu_mem_access_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-3:0] addr;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/lsu_mem_access.sv
// Execute-side load/store memory access: big-endian lane steering, byte enables,
// load extraction/extension and effective-address return, one outstanding request.
module lsu_mem_access #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [1:0]        mode,
    input  logic              exts,
    input  logic              return_dout,
    input  logic              do_request,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic              res_valid,
    output logic [DATA_W-1:0] res,
    output logic              misalign_err,
    lsu_mem_access_if.master  dmem
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        lat_mode;
    logic              lat_exts;
    logic              lat_ret;
    logic [ADDR_W-1:0] lat_addr;
    logic [3:0]        be_next;
    logic [DATA_W-1:0] wdata_next;
    logic              aligned;
    logic              accept;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [DATA_W-1:0] load_data;

    // req and stall come straight from the state register so an async reset drops them at once
    assign stall    = (state == REQ);
    assign dmem.req = (state == REQ);

    always_comb begin
        be_next    = 4'b0000;
        wdata_next = wdata;
        aligned    = 1'b1;
        case (mode)
            2'd1: begin
                be_next    = 4'b1000 >> addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'd2: begin
                be_next    = addr[1] ? 4'b0011 : 4'b1100;
                wdata_next = {2{wdata[15:0]}};
                aligned    = ~addr[0];
            end
            2'd3: begin
                be_next = 4'b1111;
                aligned = (addr[1:0] == 2'b00);
            end
            default: begin
                be_next = 4'b0000;
            end
        endcase
    end

    assign accept = (state == IDLE) && en && do_request && (mode != 2'd0) && aligned;

    always_comb begin
        lane_byte = dmem.rdata[31:24];
        case (lat_addr[1:0])
            2'd0: lane_byte = dmem.rdata[31:24];
            2'd1: lane_byte = dmem.rdata[23:16];
            2'd2: lane_byte = dmem.rdata[15:8];
            2'd3: lane_byte = dmem.rdata[7:0];
            default: lane_byte = dmem.rdata[31:24];
        endcase
        lane_half = lat_addr[1] ? dmem.rdata[15:0] : dmem.rdata[31:16];
        case (lat_mode)
            2'd1: load_data = lat_exts ? {{(DATA_W-8){lane_byte[7]}}, lane_byte}
                                       : {{(DATA_W-8){1'b0}}, lane_byte};
            2'd2: load_data = lat_exts ? {{(DATA_W-16){lane_half[15]}}, lane_half}
                                       : {{(DATA_W-16){1'b0}}, lane_half};
            default: load_data = dmem.rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = REQ;
            REQ:  if (dmem.ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid    <= 1'b0;
            res          <= '0;
            misalign_err <= 1'b0;
            dmem.we      <= 1'b0;
            dmem.addr    <= '0;
            dmem.be      <= 4'b0000;
            dmem.wdata   <= '0;
            lat_mode     <= 2'd0;
            lat_exts     <= 1'b0;
            lat_ret      <= 1'b0;
            lat_addr     <= '0;
        end else begin
            res_valid    <= 1'b0;
            misalign_err <= 1'b0;
            if (state == IDLE && en) begin
                if (!do_request) begin
                    res       <= DATA_W'(addr);
                    res_valid <= 1'b1;
                end else if (mode != 2'd0) begin
                    if (!aligned) begin
                        misalign_err <= 1'b1;
                    end else begin
                        dmem.we    <= we;
                        dmem.addr  <= addr[ADDR_W-1:2];
                        dmem.be    <= be_next;
                        dmem.wdata <= wdata_next;
                        lat_mode   <= mode;
                        lat_exts   <= exts;
                        lat_ret    <= return_dout;
                        lat_addr   <= addr;
                    end
                end
            end else if (state == REQ && dmem.ack) begin
                // a store only reports when it is an update form; a load always reports
                if (dmem.we) begin
                    if (!lat_ret) begin
                        res       <= DATA_W'(lat_addr);
                        res_valid <= 1'b1;
                    end
                end else begin
                    res       <= lat_ret ? load_data : DATA_W'(lat_addr);
                    res_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Bench for lsu_mem_access: directed vector table, reset-in-flight sequence and
// randomized ops checked against a byte-level behavioural model.
module tb_lsu_mem_access;

    typedef struct packed {
        logic        we;
        logic [1:0]  mode;
        logic        exts;
        logic        ret;
        logic        doreq;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  waits;
    } op_t;

    typedef struct packed {
        logic        req;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        valid;
        logic [31:0] res;
        logic        mis;
    } exp_t;

    typedef struct {
        string name;
        op_t   op;
        exp_t  e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        exts = 1'b0;
    logic        return_dout = 1'b0;
    logic        do_request = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall;
    logic        res_valid;
    logic [31:0] res;
    logic        misalign_err;
    int          checks = 0;
    int          errors = 0;

    lsu_mem_access_if #(.DATA_W(32), .ADDR_W(32)) dmem ();

    lsu_mem_access #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .we           (we),
        .mode         (mode),
        .exts         (exts),
        .return_dout  (return_dout),
        .do_request   (do_request),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .res_valid    (res_valid),
        .res          (res),
        .misalign_err (misalign_err),
        .dmem         (dmem)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Expected behaviour derived from access size and byte offset arithmetic.
    function automatic exp_t model(input op_t op);
        exp_t   e;
        int     size;
        int     off;
        longint v;
        longint mask;
        e = '0;
        if (!op.doreq) begin
            e.valid = 1'b1;
            e.res   = op.addr;
            return e;
        end
        if (op.mode == 2'd0) return e;
        size = 1 << (int'(op.mode) - 1);
        off  = int'(op.addr[1:0]);
        if (off % size != 0) begin
            e.mis = 1'b1;
            return e;
        end
        e.req = 1'b1;
        e.be  = 4'(((1 << size) - 1) << (4 - off - size));
        for (int j = 0; j < 4; j++)
            e.wdata[8*(3-j) +: 8] = 8'(op.wdata >> (8 * (size - 1 - (j % size))));
        if (op.we) begin
            e.valid = ~op.ret;
            e.res   = op.addr;
        end else begin
            mask = (longint'(1) << (8 * size)) - 1;
            v    = longint'(op.rdata >> (8 * (4 - off - size))) & mask;
            if (op.exts && size < 4 && v[8*size-1]) v = v | ~mask;
            e.valid = 1'b1;
            e.res   = op.ret ? 32'(v) : op.addr;
        end
        return e;
    endfunction

    function automatic op_t mk_op(input logic w, input logic [1:0] m, input logic x, input logic r,
                                  input logic d, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] rd, input logic [3:0] wt);
        op_t op;
        op.we = w; op.mode = m; op.exts = x; op.ret = r; op.doreq = d;
        op.addr = a; op.wdata = wd; op.rdata = rd; op.waits = wt;
        return op;
    endfunction

    function automatic exp_t mk_exp(input logic rq, input logic [3:0] b, input logic [31:0] wd,
                                    input logic v, input logic [31:0] rs, input logic ms);
        exp_t e;
        e.req = rq; e.be = b; e.wdata = wd; e.valid = v; e.res = rs; e.mis = ms;
        return e;
    endfunction

    // Called on a falling edge; returns on the falling edge of the first cycle the unit is free again.
    task automatic applyStimulus(input string tag, input op_t op, input exp_t e);
        en          = 1'b1;
        we          = op.we;
        mode        = op.mode;
        exts        = op.exts;
        return_dout = op.ret;
        do_request  = op.doreq;
        addr        = op.addr;
        wdata       = op.wdata;
        @(posedge clk); @(negedge clk);
        checkOutput({tag, " dmem_req"}, 32'(dmem.req), 32'(e.req));
        checkOutput({tag, " stall"}, 32'(stall), 32'(e.req));
        checkOutput({tag, " misalign_err"}, 32'(misalign_err), 32'(e.mis));
        if (e.req) begin
            checkOutput({tag, " res_valid early"}, 32'(res_valid), 32'h0);
            checkOutput({tag, " dmem_we"}, 32'(dmem.we), 32'(op.we));
            checkOutput({tag, " dmem_addr"}, 32'(dmem.addr), op.addr >> 2);
            checkOutput({tag, " dmem_be"}, 32'(dmem.be), 32'(e.be));
            if (op.we) checkOutput({tag, " dmem_wdata"}, dmem.wdata, e.wdata);
            do_request = 1'b0;
            addr       = $urandom;
            mode       = 2'($urandom);
            we         = 1'($urandom);
            for (int i = 0; i < int'(op.waits); i++) begin
                dmem.ack = 1'b0;
                @(posedge clk); @(negedge clk);
                checkOutput({tag, " dmem_req held"}, 32'(dmem.req), 32'h1);
                checkOutput({tag, " dmem_be held"}, 32'(dmem.be), 32'(e.be));
                checkOutput({tag, " res_valid wait"}, 32'(res_valid), 32'h0);
            end
            dmem.ack   = 1'b1;
            dmem.rdata = op.rdata;
            @(posedge clk); @(negedge clk);
            dmem.ack   = 1'b0;
            dmem.rdata = $urandom;
            checkOutput({tag, " dmem_req done"}, 32'(dmem.req), 32'h0);
            checkOutput({tag, " stall done"}, 32'(stall), 32'h0);
            checkOutput({tag, " misalign_err done"}, 32'(misalign_err), 32'h0);
        end
        checkOutput({tag, " res_valid"}, 32'(res_valid), 32'(e.valid));
        if (e.valid) checkOutput({tag, " res"}, res, e.res);
        en = 1'b0;
    endtask

    vec_t vecs[14];
    op_t  op;
    exp_t e;

    initial begin
        dmem.ack   = 1'b0;
        dmem.rdata = 32'h0;

        vecs[0]  = '{"ldw_zero_wait", mk_op(0, 3, 0, 1, 1, 32'h100, 0, 32'hDEADBEEF, 0),
                     mk_exp(1, 4'b1111, 0, 1, 32'hDEADBEEF, 0)};
        vecs[1]  = '{"ldb_sext",      mk_op(0, 1, 1, 1, 1, 32'h103, 0, 32'h000000F0, 3),
                     mk_exp(1, 4'b0001, 0, 1, 32'hFFFFFFF0, 0)};
        vecs[2]  = '{"ldb_zext",      mk_op(0, 1, 0, 1, 1, 32'h103, 0, 32'h000000F0, 3),
                     mk_exp(1, 4'b0001, 0, 1, 32'h000000F0, 0)};
        vecs[3]  = '{"sth_update",    mk_op(1, 2, 0, 0, 1, 32'h202, 32'h1234ABCD, 0, 2),
                     mk_exp(1, 4'b0011, 32'hABCDABCD, 1, 32'h202, 0)};
        vecs[4]  = '{"ldw_update",    mk_op(0, 3, 0, 1, 1, 32'h300, 0, 32'h11223344, 1),
                     mk_exp(1, 4'b1111, 0, 1, 32'h11223344, 0)};
        vecs[5]  = '{"addr_return",   mk_op(0, 3, 0, 0, 0, 32'h300, 0, 0, 0),
                     mk_exp(0, 4'b0000, 0, 1, 32'h300, 0)};
        vecs[6]  = '{"mis_word",      mk_op(0, 3, 0, 1, 1, 32'h102, 0, 0, 0),
                     mk_exp(0, 4'b0000, 0, 0, 0, 1)};
        vecs[7]  = '{"mis_half",      mk_op(0, 2, 0, 1, 1, 32'h101, 0, 0, 0),
                     mk_exp(0, 4'b0000, 0, 0, 0, 1)};
        vecs[8]  = '{"stb_plain",     mk_op(1, 1, 0, 1, 1, 32'h101, 32'h00000055, 0, 0),
                     mk_exp(1, 4'b0100, 32'h55555555, 0, 0, 0)};
        vecs[9]  = '{"nop_mode0",     mk_op(0, 0, 0, 1, 1, 32'h200, 0, 0, 0),
                     mk_exp(0, 4'b0000, 0, 0, 0, 0)};
        vecs[10] = '{"ldh_k2_sext",   mk_op(0, 2, 1, 1, 1, 32'h206, 0, 32'h12348001, 2),
                     mk_exp(1, 4'b0011, 0, 1, 32'hFFFF8001, 0)};
        vecs[11] = '{"ldh_k0_sext",   mk_op(0, 2, 1, 1, 1, 32'h204, 0, 32'h7FFF0000, 0),
                     mk_exp(1, 4'b1100, 0, 1, 32'h00007FFF, 0)};
        vecs[12] = '{"stw_update",    mk_op(1, 3, 0, 0, 1, 32'h50C, 32'hA1B2C3D4, 0, 1),
                     mk_exp(1, 4'b1111, 32'hA1B2C3D4, 1, 32'h50C, 0)};
        vecs[13] = '{"stb_lane3",     mk_op(1, 1, 0, 1, 1, 32'h107, 32'h123456EF, 0, 0),
                     mk_exp(1, 4'b0001, 32'hEFEFEFEF, 0, 0, 0)};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        checkOutput("reset stall", 32'(stall), 32'h0);
        checkOutput("reset res_valid", 32'(res_valid), 32'h0);
        checkOutput("reset misalign_err", 32'(misalign_err), 32'h0);
        checkOutput("reset dmem_req", 32'(dmem.req), 32'h0);
        checkOutput("reset dmem_we", 32'(dmem.we), 32'h0);
        checkOutput("reset dmem_addr", 32'(dmem.addr), 32'h0);
        checkOutput("reset dmem_be", 32'(dmem.be), 32'h0);
        checkOutput("reset dmem_wdata", dmem.wdata, 32'h0);
        checkOutput("reset res", res, 32'h0);

        dmem.ack = 1'b1;
        @(posedge clk); @(negedge clk);
        dmem.ack = 1'b0;
        checkOutput("stray ack res_valid", 32'(res_valid), 32'h0);
        checkOutput("stray ack stall", 32'(stall), 32'h0);

        for (int i = 0; i < 14; i++) applyStimulus(vecs[i].name, vecs[i].op, vecs[i].e);

        // Reset while a load is outstanding: request drops at once and a late ack is ignored.
        en = 1'b1; we = 1'b0; mode = 2'd3; exts = 1'b0; return_dout = 1'b1;
        do_request = 1'b1; addr = 32'h400; wdata = 32'h0;
        @(posedge clk); @(negedge clk);
        en = 1'b0;
        checkOutput("rst_mid dmem_req before", 32'(dmem.req), 32'h1);
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_mid dmem_req", 32'(dmem.req), 32'h0);
        checkOutput("rst_mid stall", 32'(stall), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        dmem.ack = 1'b1;
        dmem.rdata = 32'h99999999;
        @(posedge clk); @(negedge clk);
        dmem.ack = 1'b0;
        checkOutput("rst_mid late ack res_valid", 32'(res_valid), 32'h0);
        checkOutput("rst_mid late ack dmem_req", 32'(dmem.req), 32'h0);
        applyStimulus("after_reset_ldw", mk_op(0, 3, 0, 1, 1, 32'h404, 0, 32'hCAFEF00D, 1),
                      mk_exp(1, 4'b1111, 0, 1, 32'hCAFEF00D, 0));

        for (int i = 0; i < 300; i++) begin
            op.we    = 1'($urandom);
            op.mode  = 2'($urandom);
            op.exts  = 1'($urandom);
            op.doreq = ($urandom_range(0, 7) != 0);
            op.ret   = op.we ? 1'($urandom) : 1'b1;
            op.addr  = $urandom;
            op.wdata = $urandom;
            op.rdata = $urandom;
            op.waits = 4'($urandom_range(0, 3));
            e = model(op);
            applyStimulus($sformatf("rand%0d", i), op, e);
        end

        @(posedge clk); @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_access.md
# lsu_mem_access

Load/store execute-side memory access unit. Consumes the registered load/store control word from the load/store decode stage (`Load_store_ctrl_if` fields), together with the AGU effective address and the store operand. It drives a single-outstanding data-memory request/acknowledge bus, does big-endian lane steering, byte enables and load extraction/sign extension, and returns either load data or the effective address (update forms) to writeback. It stalls the pipeline while a memory transaction is outstanding.

## Interface
Parameters:
- `DATA_W`, 32: data width; fixed at 32 (4 byte lanes).
- `ADDR_W`, 32: byte address width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `en`  in  1  control word valid (decode `en_dec`).
- `we`  in  1  store when 1, load when 0.
- `mode`  in  2  access size: 0 Load_null, 1 Load_byte, 2 Load_halfword, 3 Load_word.
- `exts`  in  1  sign-extend byte/halfword load result.
- `return_dout`  in  1  result is load data (1) or effective address (0).
- `do_request`  in  1  perform memory access this op.
- `addr`  in  ADDR_W  effective byte address.
- `wdata`  in  32  store operand, right-aligned.
- `stall`  out  1  unit busy; upstream holds all inputs.
- `res_valid`  out  1  one-cycle result strobe.
- `res`  out  32  result.
- `misalign_err`  out  1  one-cycle alignment fault pulse.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  memory write.
- `dmem_addr`  out  ADDR_W-2  word address.
- `dmem_be`  out  4  byte enables; bit 3 = bits 31:24.
- `dmem_wdata`  out  32  lane-steered store data.
- `dmem_ack`  in  1  request complete; read data valid this cycle.
- `dmem_rdata`  in  32  read data.

## Operation
- States: IDLE, REQ. `stall` = (state == REQ).
- In IDLE, inputs are sampled when `en`=1. Inputs are ignored in REQ.
- Accept with `do_request`=1, `mode`≠0 and aligned access:
  - Register `dmem_we`, `dmem_addr`=`addr[ADDR_W-1:2]`, `dmem_be`, `dmem_wdata`; also latch `exts`, `mode`, `addr[1:0]`, `return_dout`, `addr`.
  - Go to REQ.
- Alignment: halfword requires `addr[0]`=0; word requires `addr[1:0]`=0.
  - Misaligned: no request; `misalign_err`=1 next cycle; no `res_valid`; stay IDLE.
- Big-endian lanes. Byte offset k maps to bits [31-8k:24-8k].
  - Byte: `be` = 4'b1000>>k; `wdata[7:0]` replicated to all lanes.
  - Halfword: `be` = 1100 (k=0) or 0011 (k=2); `wdata[15:0]` replicated.
  - Word: `be` = 1111.
- REQ: hold `dmem_req`=1 and all `dmem_*` outputs stable until `dmem_ack`=1. On ack, return to IDLE.
- Load completion (`return_dout`=1):
  - `res` = selected lane, zero-extended, or sign-extended from bit 7/15 when `exts`=1.
  - Word: `res` = `dmem_rdata`.
- Store completion: `res_valid` only if `return_dout`=0; then `res` = latched `addr`. Plain stores produce no result.
- `en`=1, `do_request`=0: this is the address-return cycle of a load-update. No memory access; `res` = `addr`, `res_valid` next cycle, stay IDLE.
- `en`=1, `mode`=0, `do_request`=1: no-op; no outputs.
- `dmem_ack` outside REQ is ignored.

## Timing
- Reset values: state IDLE; `stall`, `res_valid`, `misalign_err`, `dmem_req`, `dmem_we` = 0; `dmem_addr`, `dmem_be`, `dmem_wdata`, `res` = 0.
- Accept in cycle N. `dmem_req` rises N+1 and `stall` is 1 from N+1.
- Ack in cycle M ≥ N+1; zero-wait ack in N+1 is legal.
  - `dmem_req` and `stall` are 0 in M+1.
  - `res_valid`/`res` are registered and valid in M+1.
  - A new op may be accepted in M+1.
- Load latency: 2 + wait cycles from accept to `res_valid`.
- Non-request address return: `res_valid` at N+1. Misalign pulse at N+1.
- `res_valid` and `misalign_err` are single-cycle pulses and never assert together.
- Reset mid-transaction: `dmem_req` and `stall` drop immediately (asynchronous). The pending result is discarded; a late `dmem_ack` is ignored.

## Test plan
- Zero-wait load word: `addr`=0x100, rdata=0xDEADBEEF, ack at N+1 -> `dmem_addr`=0x40, `be`=1111, `res`=0xDEADBEEF at N+2.
- Byte loads, 3 wait states:
  - `addr`=0x103, `exts`=1, rdata=0x000000F0 -> `be`=0001; `stall` N+1..N+4; `res`=0xFFFFFFF0 at N+5.
  - Same with `exts`=0 -> `res`=0x000000F0.
- Halfword store-update: `addr`=0x202, `wdata`=0x1234ABCD, `return_dout`=0 -> `be`=0011, `dmem_wdata`=0xABCDABCD, `res`=0x202 one cycle after ack.
- Load-update pair: op1 load with `return_dout`=1, then op2 with `do_request`=0, `addr`=0x300 -> data result, then `res`=0x300 with no second `dmem_req`.
- Misaligned accesses: word at 0x102 and halfword at 0x101 -> `misalign_err` pulse each; `dmem_req` never asserts.
- Reset asserted while in REQ -> `dmem_req`=0 same cycle; subsequent ack produces no `res_valid`; next load after reset completes normally.
